// File: rtl/fdiv_ctrl_if.sv
// Ratio reconfiguration handshake between the config requester and fdiv_ctrl.
// The requester holds cfg_valid/cfg_n until cfg_ready is seen high at a posedge.
interface fdiv_ctrl_if #(
  parameter int W = 8
);
  logic         cfg_valid;
  logic [W-1:0] cfg_n;
  logic         cfg_ready;
  logic         err;

  modport master (output cfg_valid, cfg_n, input cfg_ready, err);
  modport slave  (input cfg_valid, cfg_n, output cfg_ready, err);
endinterface

// File: rtl/fdiv_ctrl.sv
// 50%-duty integer clock divider with clean run/stop and runt-free ratio updates.
// New ratios are staged in a shadow register and loaded only at a period boundary.
//
// state | meaning
// IDLE  | output parked low, counter held at 0, pending ratio loads on next posedge
// RUN   | producing periods, counting m = 0..cur_n-1
// DRAIN | en dropped; finish the current period, then return to IDLE
module fdiv_ctrl #(
  parameter int W     = 8,
  parameter int N_DEF = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  fdiv_ctrl_if.slave   cfg,
  output logic         q,
  output logic         tick,
  output logic         busy,
  output logic [W-1:0] cur_n
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t       state, state_nx;
  logic [W-1:0] m, m_nx, n_nx, shadow;
  logic         pend, clk1, clk1_nx, clk2, err_r;
  logic         boundary, apply, accept;

  assign accept = cfg.cfg_valid && !pend;

  always_comb begin
    state_nx = state;
    m_nx     = m;
    n_nx     = cur_n;
    boundary = (state != IDLE) && (m == cur_n - W'(1));
    // pend is registered, so a ratio never applies on its own accept edge
    apply    = pend && ((state == IDLE) || boundary);
    if (apply) n_nx = shadow;
    case (state)
      IDLE: begin
        m_nx = '0;
        if (en) state_nx = RUN;
      end
      RUN, DRAIN: begin
        m_nx = boundary ? '0 : m + W'(1);
        if (en)            state_nx = RUN;
        else if (boundary) state_nx = IDLE;
        else               state_nx = DRAIN;
      end
      default: begin
        state_nx = IDLE;
        m_nx     = '0;
      end
    endcase
    clk1_nx = (state_nx != IDLE) && (m_nx < (n_nx >> 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      m      <= '0;
      cur_n  <= W'(N_DEF);
      shadow <= W'(N_DEF);
      pend   <= 1'b0;
      clk1   <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      state <= state_nx;
      m     <= m_nx;
      cur_n <= n_nx;
      clk1  <= clk1_nx;
      err_r <= accept && (cfg.cfg_n < W'(2));
      if (apply) begin
        pend <= 1'b0;
      end else if (accept && (cfg.cfg_n >= W'(2))) begin
        shadow <= cfg.cfg_n;
        pend   <= 1'b1;
      end
    end
  end

  // Half-cycle extension of the high phase for odd ratios
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) clk2 <= 1'b0;
    else      clk2 <= clk1 & cur_n[0];
  end

  assign q             = clk1 | clk2;
  assign tick          = (state != IDLE) && (m == '0);
  assign busy          = (state != IDLE);
  assign cfg.cfg_ready = !pend;
  assign cfg.err       = err_r;

endmodule

// File: tb/tb_fdiv_ctrl.sv
// Directed bench for fdiv_ctrl: q is sampled every half cycle and compared to
// the ideal pattern of a period of N (high for N half-cycles, low for N).
module tb_fdiv_ctrl;
  logic       clk, rst, en;
  logic       q, tick, busy;
  logic [7:0] cur_n;
  int         vec  = 0;
  int         errs = 0;

  fdiv_ctrl_if #(.W(8)) cif ();

  fdiv_ctrl #(.W(8), .N_DEF(9)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .cfg   (cif.slave),
    .q     (q),
    .tick  (tick),
    .busy  (busy),
    .cur_n (cur_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input string tag);
    en = 1'b1;
    step();
    chk({tag, "_busy"}, 64'(busy), 64'd1);
  endtask

  // Called at posedge+1 of a period's first cycle; returns at posedge+1 of the next.
  task automatic check_period(input int n, input string tag, input int drop_at,
                              input int raise_at, input int cfg_at, input logic [7:0] cfg_val);
    logic [63:0] obs, exp, tk;
    logic [7:0]  n_before;
    obs = '0; exp = '0; tk = '0;
    n_before = cur_n;
    for (int i = 0; i < n; i++) begin
      if (i == drop_at)  en = 1'b0;
      if (i == raise_at) en = 1'b1;
      if (i == cfg_at) begin
        cif.cfg_valid = 1'b1;
        cif.cfg_n     = cfg_val;
      end
      obs[2*i] = q;
      tk[i]    = tick;
      @(negedge clk);
      #1;
      obs[2*i+1] = q;
      step();
      if (i == cfg_at) begin
        cif.cfg_valid = 1'b0;
        chk({tag, "_ready_lo"}, 64'(cif.cfg_ready), 64'd0);
        chk({tag, "_curn_hold"}, 64'(cur_n), 64'(n_before));
      end
    end
    for (int j = 0; j < 2*n; j++) exp[j] = (j < n);
    chk({tag, "_q"}, obs, exp);
    chk({tag, "_tick"}, tk, 64'd1);
  endtask

  task automatic send_cfg(input logic [7:0] n, input string tag);
    logic acc;
    acc = 1'b0;
    cif.cfg_valid = 1'b1;
    cif.cfg_n     = n;
    for (int k = 0; k < 64 && !acc; k++) begin
      acc = cif.cfg_ready;
      step();
    end
    cif.cfg_valid = 1'b0;
    chk({tag, "_accepted"}, 64'(acc), 64'd1);
  endtask

  task automatic cfg_idle(input logic [7:0] n, input logic [7:0] old_n, input string tag);
    send_cfg(n, tag);
    chk({tag, "_curn_old"}, 64'(cur_n), 64'(old_n));
    chk({tag, "_ready_lo"}, 64'(cif.cfg_ready), 64'd0);
    step();
    chk({tag, "_curn_new"}, 64'(cur_n), 64'(n));
    chk({tag, "_ready_hi"}, 64'(cif.cfg_ready), 64'd1);
  endtask

  task automatic run_ratio(input int n, input string tag);
    start_run(tag);
    check_period(n, {tag, "_p1"}, -1, -1, -1, 8'd0);
    check_period(n, {tag, "_p2"}, 0, -1, -1, 8'd0);
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    chk({tag, "_idle_q"}, 64'(q), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; en = 1'b0;
    cif.cfg_valid = 1'b0; cif.cfg_n = 8'd0;
    #12;
    chk("rst_q", 64'(q), 64'd0);
    chk("rst_tick", 64'(tick), 64'd0);
    chk("rst_err", 64'(cif.err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(cif.cfg_ready), 64'd1);
    chk("rst_curn", 64'(cur_n), 64'd9);
    rst = 1'b1;
    step();

    // Default ratio 9
    run_ratio(9, "n9");
    chk("n9_curn", 64'(cur_n), 64'd9);

    // Ratios configured while idle
    cfg_idle(8'd2, 8'd9, "c2");
    run_ratio(2, "n2");
    cfg_idle(8'd3, 8'd2, "c3");
    run_ratio(3, "n3");
    cfg_idle(8'd10, 8'd3, "c10");
    run_ratio(10, "n10");

    // Illegal ratios
    send_cfg(8'd0, "e0");
    chk("e0_err", 64'(cif.err), 64'd1);
    chk("e0_ready", 64'(cif.cfg_ready), 64'd1);
    chk("e0_curn", 64'(cur_n), 64'd10);
    step();
    chk("e0_err_clr", 64'(cif.err), 64'd0);
    send_cfg(8'd1, "e1");
    chk("e1_err", 64'(cif.err), 64'd1);
    chk("e1_ready", 64'(cif.cfg_ready), 64'd1);
    step();
    chk("e1_err_clr", 64'(cif.err), 64'd0);
    chk("e1_curn", 64'(cur_n), 64'd10);
    run_ratio(10, "n10b");

    // Reconfiguration mid-period: 9 -> 4 at the boundary
    cfg_idle(8'd9, 8'd10, "c9");
    start_run("rc");
    check_period(9, "rc9", -1, -1, 3, 8'd4);
    chk("rc_curn4", 64'(cur_n), 64'd4);
    chk("rc_ready", 64'(cif.cfg_ready), 64'd1);
    check_period(4, "rc4a", -1, -1, -1, 8'd0);
    check_period(4, "rc4b", 0, -1, -1, 8'd0);
    chk("rc_idle", 64'(busy), 64'd0);

    // Stop and resume at N=7
    cfg_idle(8'd7, 8'd4, "c7");
    start_run("sr");
    check_period(7, "sr1", -1, -1, -1, 8'd0);
    check_period(7, "sr_drain", 2, 5, -1, 8'd0);
    chk("sr_resume_busy", 64'(busy), 64'd1);
    check_period(7, "sr_cont", -1, -1, -1, 8'd0);
    check_period(7, "sr_stop", 3, -1, -1, 8'd0);
    chk("sr_stop_busy", 64'(busy), 64'd0);
    for (int k = 0; k < 3; k++) begin
      chk("sr_quiet_q", 64'(q), 64'd0);
      step();
    end

    // Async reset in the high phase
    start_run("ar");
    step();
    chk("ar_q_high", 64'(q), 64'd1);
    #3;
    rst = 1'b0;
    en  = 1'b0;
    #1;
    chk("ar_q", 64'(q), 64'd0);
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_curn", 64'(cur_n), 64'd9);
    #2;
    rst = 1'b1;
    step();
    chk("ar_post_curn", 64'(cur_n), 64'd9);
    chk("ar_post_q", 64'(q), 64'd0);
    chk("ar_post_ready", 64'(cif.cfg_ready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/fdiv_ctrl.md
# fdiv_ctrl

Run/stop and reconfiguration controller for the 50%-duty integer clock divider. It owns the divide counter and the posedge/negedge duty-shaping registers. It accepts a new ratio N over a valid/ready handshake and applies it only at a period boundary, so the divided clock never shows a runt pulse. It starts and stops the output cleanly on complete periods and sits between the register/config interface and any logic clocked from the divided output.

## Interface
- W, 8, width of ratio and counter; legal N range 2..2^W-1
- N_DEF, 9, ratio loaded at reset; must be 2..2^W-1
- clk  input  1  reference clock; both edges used
- rst  input  1  asynchronous, active-low reset
- en  input  1  run request, sampled on posedge clk
- cfg_valid  input  1  new-ratio request
- cfg_n  input  W  requested ratio N
- cfg_ready  output  1  high when no ratio is pending (= !pend)
- err  output  1  one-cycle pulse when a handshake carries N<2; no ratio is stored
- q  output  1  divided clock, 50% duty for odd and even N
- tick  output  1  high during the first clk cycle of every output period (m==0 while running)
- busy  output  1  high in RUN or DRAIN
- cur_n  output  W  ratio currently in effect

## Operation
- Registers:
  - state {IDLE, RUN, DRAIN}
  - m[W-1:0], posedge counter 0..cur_n-1
  - cur_n
  - shadow[W-1:0] and pend
  - clk1 (posedge)
  - clk2 (negedge)
  - odd = cur_n[0]
- Duty shaping:
  - H = floor(cur_n/2).
  - clk1 <= running && (m_next < H).
  - On negedge clk, clk2 <= clk1 & odd.
  - q = clk1 | clk2.
  - Odd N: high time is H + 0.5 cycles. Even N: high time is H cycles.
- Handshake:
  - Accept on cfg_valid && cfg_ready at a posedge. If cfg_n >= 2: shadow <= cfg_n, pend <= 1. If cfg_n < 2: pulse err, pend unchanged.
  - cfg_valid while cfg_ready=0 is ignored; the requester holds it.
- Apply point:
  - A pending ratio loads (cur_n <= shadow, pend <= 0) at the first qualifying edge strictly after the accept edge.
  - In IDLE, the qualifying edge is the next posedge.
  - In RUN or DRAIN, the qualifying edge is the boundary edge, i.e. the edge where m==cur_n-1. That edge sets m to 0 and starts the period with the new N, using the new H for clk1.
- State machine:
  - IDLE: m=0, clk1=0. When en=1 at an edge: go to RUN, m=0, clk1<=1, tick<=1. q rises at that edge.
  - RUN: m increments and wraps at cur_n-1. When en=0 at an edge: go to DRAIN and keep counting.
  - DRAIN: when en=1: return to RUN with no gap or phase change. At the boundary edge with en=0: go to IDLE, m=0, clk1=0, tick=0.
- Boundary cases:
  - If en falls on the boundary edge itself, the current period completes and IDLE is entered at that edge; no extra period is produced.
  - A ratio accepted on a boundary edge waits for the next boundary.
  - An async reset mid-period forces q=0 immediately, both edge registers included.

## Timing
- Reset values:
  - state=IDLE, m=0, cur_n=N_DEF, shadow=N_DEF
  - pend=0, clk1=0, clk2=0
  - q=0, tick=0, err=0, busy=0, cfg_ready=1
- Start latency: the q rising edge follows the posedge that samples en=1 in IDLE (clock-to-q only).
- Stop: q stays low after the last complete period. busy falls at the IDLE-entry edge.
- Reconfig latency: at most cur_n + 1 posedges from accept to the new period.
- cur_n, tick and cfg_ready update on posedge clk only. clk2 is the only negedge register.

## Test plan
- **Reset and start:** release rst; en=1 with N_DEF=9 -> q high 4.5 cycles and low 4.5 cycles, period 9; tick every 9 cycles; busy=1.
- **Even and odd ratios, configured in IDLE:**
  - N=2 -> q toggles high 1 cycle / low 1 cycle.
  - N=3 -> high 1.5 / low 1.5.
  - N=10 -> high 5 / low 5.
  - In each case cur_n updates one edge after accept.
- **Glitch-free reconfiguration:** while running N=9, send cfg_n=4 mid-period -> cfg_ready low until the boundary; the 9-cycle period completes, then 4-cycle periods follow with high 2; no runt pulse.
- **Illegal ratio:** cfg_n=0 and cfg_n=1 -> err pulses one cycle each; cur_n and pend are unchanged.
- **Stop and resume:**
  - en falls at m=3 of N=7 -> q finishes the period, then goes idle with q=0.
  - en re-raised at m=5 during DRAIN -> uninterrupted periodic output.
- **Async reset mid-high-phase:** assert rst while q=1 -> q=0 immediately, with no clock edge needed; after release, cur_n=N_DEF.
